// File: rtl/affine_seq.sv
// Moore control sequencer for the PicoMIPS affine-transform datapath.
// Steps one point through MX/MY for row 0 (X') and row 1 (Y'), then presents the result.
module affine_seq #(
   parameter bit FRAC   = 1'b1,
   parameter int W_CTRL = 6
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_CTRL-1:0] op,
   output logic [1:0]        coef_sel,
   output logic              off_sel,
   output logic              ld_xy,
   output logic              acc_en,
   output logic              wr_x,
   output logic              wr_y,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MX,
      MY,
      WB,
      DONE
   } state_t;

   // tOP word layout: {frac_c, wdual, mul_a_sel[1:0], add_b_sel[1:0]}
   localparam logic [W_CTRL-1:0] OP_MX = {FRAC, 1'b0, 2'b00, 2'b10};
   localparam logic [W_CTRL-1:0] OP_MY = {FRAC, 1'b0, 2'b01, 2'b01};
   localparam logic [W_CTRL-1:0] OP_WD = {1'b0, 1'b1, 2'b00, 2'b00};

   state_t state, state_nx;
   logic   r, r_nx;
   // Held low through reset so in_ready stays low while nReset is asserted,
   // without routing nReset combinationally to any output.
   logic   armed;

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state <= IDLE;
         r     <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         r     <= r_nx;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      r_nx      = r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      op        = '0;
      coef_sel  = 2'b00;
      off_sel   = 1'b0;
      ld_xy     = 1'b0;
      acc_en    = 1'b0;
      wr_x      = 1'b0;
      wr_y      = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
            in_ready = armed;
            if (armed && in_valid) begin
               state_nx = LOAD;
               r_nx     = 1'b0;
            end
         end
         LOAD: begin
            ld_xy    = 1'b1;
            state_nx = MX;
         end
         MX: begin
            op       = OP_MX;
            coef_sel = {r, 1'b0};
            off_sel  = r;
            acc_en   = 1'b1;
            state_nx = MY;
         end
         MY: begin
            op       = OP_MY;
            coef_sel = {r, 1'b1};
            acc_en   = 1'b1;
            state_nx = WB;
         end
         WB: begin
            if (!r) begin
               wr_x     = 1'b1;
               r_nx     = 1'b1;
               state_nx = MX;
            end else begin
               // wdual commits the X' shadow together with Y'
               wr_y     = 1'b1;
               op       = OP_WD;
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
               r_nx     = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            r_nx     = 1'b0;
         end
      endcase

      if (abort && (state != IDLE)) begin
         state_nx = IDLE;
         r_nx     = 1'b0;
      end
   end

endmodule

// File: doc/affine_seq.md
Name: affine_seq

Overview:
- Control sequencer for the PicoMIPS affine-transform datapath.
- Takes an input point through the shared multiply/add ALU in six micro-steps: X' = C00·x + C01·y + B0, then Y' = C10·x + C11·y + B1.
- Drives the 6-bit tOP control word, coefficient/offset selects and register write strobes.
- Sits between the switch/host handshake and the datapath; contains no arithmetic itself.

Parameters:
- FRAC, 1, value driven on the tOP.frac_c bit during multiply steps (1 = coefficients are Q1.7 fractions).
- W_CTRL, 6, width of the packed tOP control word; fixed at 6.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- nReset  in  1  synchronous active-low reset
- abort  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  input point (x, y) presented to the datapath input registers
- in_ready  out  1  block can accept a point
- out_valid  out  1  X'/Y' result registers hold a new result
- out_ready  in  1  consumer accepts the result
- op  out  6  tOP word {frac_c, wdual, mul_a_sel[1:0], add_b_sel[1:0]}
- coef_sel  out  2  coefficient index {row, col}
- off_sel  out  1  offset index (row)
- ld_xy  out  1  load x/y input registers
- acc_en  out  1  accumulator write enable
- wr_x  out  1  write X' shadow register
- wr_y  out  1  write Y' register; with wdual, also commit the X' shadow
- busy  out  1  state is not IDLE

Behaviour:
- Encodings:
  - mul_a_sel: 00 = x, 01 = y, 10 = acc, 11 = zero.
  - add_b_sel: 00 = zero, 01 = acc, 10 = offset, 11 = reserved (never driven).
- Moore FSM. All outputs are decoded from registered state and row bit only. No combinational path from any input to any output.
- States: IDLE, LOAD, MX, MY, WB, DONE. One row bit r.
- Reset (nReset = 0 at an edge):
  - state = IDLE, r = 0.
  - While nReset is low: in_ready = 0, out_valid = 0, op = 0, coef_sel = 0, off_sel = 0, all strobes = 0, busy = 0.
- IDLE:
  - in_ready = 1. Other outputs 0.
  - in_valid = 1 at an edge → LOAD, r = 0.
- LOAD: ld_xy = 1 → MX.
- MX:
  - op = {FRAC, 0, 00, 10}, coef_sel = {r, 0}, off_sel = r, acc_en = 1.
  - Datapath result: acc = C·x + B.
  - → MY.
- MY:
  - op = {FRAC, 0, 01, 01}, coef_sel = {r, 1}, acc_en = 1.
  - Datapath result: acc = C·y + acc.
  - → WB.
- WB, r = 0: wr_x = 1, op = 0, → MX with r = 1.
- WB, r = 1: wr_y = 1, op.wdual = 1 (X' and Y' become visible in the same cycle), → DONE.
- DONE:
  - out_valid = 1, held until out_ready = 1 at an edge.
  - Then → IDLE, r = 0.
- Latency:
  - Accepting edge E0; LOAD is the cycle after E0.
  - out_valid first high in the 8th cycle after E0.
  - Minimum occupancy 9 cycles when out_ready is already high.
- No back-to-back overlap: in_ready is low in every state except IDLE. An in_valid arriving during DONE waits.
- in_valid and out_ready may stay high continuously. The IDLE cycle between results is mandatory, giving a throughput of 1 point per 9 cycles.
- abort = 1 at an edge in any state other than IDLE:
  - → IDLE, r = 0.
  - No wr_* strobe in the following cycle.
  - out_valid is dropped even if the result was not consumed.
  - abort in IDLE is ignored.
- Priority: nReset over abort over normal transitions.
- Reset or abort mid-sequence after wr_x but before wr_y: the X' shadow holds a stale value, but the visible output is unchanged because wdual never fired.

Test Plan:
- Reset: hold nReset = 0 for 3 cycles with in_valid = 1 → all outputs 0 and in_ready = 0; first cycle after release: in_ready = 1, busy = 0.
- Single transaction, out_ready = 1, FRAC = 1: in_valid pulse at E0 → ld_xy at E0+1; op = 0x22 / coef_sel = 0 at +2; op = 0x25 / coef_sel = 1 at +3; wr_x at +4; coef_sel = 2 / off_sel = 1 at +5; coef_sel = 3 at +6; wr_y with op = 0x10 at +7; out_valid at +8; in_ready back at +9.
- Backpressure: out_ready = 0 for 5 cycles in DONE → out_valid held 5 cycles, in_ready stays 0, no strobes; out_ready = 1 → IDLE next cycle.
- Continuous in_valid = out_ready = 1 over 3 points → ld_xy pulses exactly 9 cycles apart, 3 wr_y pulses, never two strobes in the same cycle.
- abort in MY of row 1 → IDLE next cycle, no wr_y, no out_valid; the next in_valid completes normally.
- nReset = 0 during DONE with out_valid = 1 → out_valid = 0 the following cycle, state IDLE, r = 0.
